// File: rtl/sched_pkg.sv
// ============================================================================
// Package  : sched_pkg
// Brief    : Shared types and constants for the 4:2:0 MCU chroma scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sched_pkg;

    localparam int BLK_DW   = 9;
    localparam int MCU_BLKS = 6;
    localparam int QUADS    = 4;
    localparam int SUBS     = 3;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } ch_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } sched_state_t;

    typedef logic [7:0][7:0][BLK_DW-1:0] blk8_t;
    typedef logic [3:0][3:0][BLK_DW-1:0] blk4_t;

    // JPEG scan order within one MCU: Y0..Y3, Cb, Cr
    function automatic ch_t expected_ch(input logic [2:0] cnt);
        if (cnt < 3'd4)
            return CH_Y;
        else if (cnt == 3'd4)
            return CH_CB;
        return CH_CR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chroma_quad_sel.sv
// ============================================================================
// Module   : chroma_quad_sel
// Brief    : Combinational 8x8 -> 4x4 quadrant extractor for one chroma block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chroma_quad_sel #(
    parameter int DW = 9
) (
    input  logic signed [7:0][7:0][DW-1:0] blk,
    input  logic        [1:0]              q,
    output logic signed [3:0][3:0][DW-1:0] quad
);

    // q[1] selects the row half, q[0] the column half
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign quad[r][c] = blk[{q[1], 2'(r)}][{q[0], 2'(c)}];
        end
    end

endmodule

`default_nettype wire

// File: rtl/chroma_mcu_sched.sv
// ============================================================================
// Module   : chroma_mcu_sched
// Brief    : Collects Y0..Y3/Cb/Cr of a 4:2:0 MCU and re-issues them as
//            Y_q, Cb quadrant q, Cr quadrant q. Option: CHROMA_SCHED_PINGPONG_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module chroma_mcu_sched
    import sched_pkg::*;
#(
    parameter  int DW  = 9,
    parameter  int NCH = 3,
    localparam int CHW = $clog2(NCH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic        [CHW-1:0]         in_ch,
    input  logic signed [7:0][7:0][DW-1:0] in_block,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic        [CHW-1:0]         out_ch,
    output logic        [1:0]             out_quad,
    output logic signed [7:0][7:0][DW-1:0] out_y_block,
    output logic signed [3:0][3:0][DW-1:0] out_sub_block,
    input  logic                          out_ready,
    output logic                          mcu_done,
    output logic                          seq_err
);

    // Bank 1 is only ever addressed with ping-pong enabled
    logic [7:0][7:0][DW-1:0] y_mem  [2][4];
    logic [7:0][7:0][DW-1:0] cb_mem [2];
    logic [7:0][7:0][DW-1:0] cr_mem [2];

    sched_state_t state, state_nxt;
    logic [2:0]   blk_cnt;
    logic [1:0]   q;
    logic [1:0]   sub;

    logic accept, fill_done, beat_take, last_shown, last_take;
    logic load, finish, switch_buf;
    logic wbuf, src_buf;

    logic [7:0][7:0][DW-1:0] chroma_src;
    logic signed [3:0][3:0][DW-1:0] chroma_quad;

    assign accept     = in_valid && in_ready;
    assign fill_done  = accept && (blk_cnt == 3'(MCU_BLKS - 1));
    assign beat_take  = out_valid && out_ready;
    assign last_shown = (out_quad == 2'(QUADS - 1)) && (out_ch == CHW'(SUBS - 1));
    assign last_take  = beat_take && last_shown;

`ifdef CHROMA_SCHED_PINGPONG_EN
    logic [1:0] full;
    logic       rbuf;

    assign in_ready   = !full[wbuf];
    assign switch_buf = last_take && full[~rbuf];
    assign src_buf    = switch_buf ? ~rbuf : rbuf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
            wbuf <= 1'b0;
            rbuf <= 1'b0;
        end else begin
            if (fill_done) begin
                full[wbuf] <= 1'b1;
                wbuf       <= ~wbuf;
            end
            if (finish) begin
                full[rbuf] <= 1'b0;
                rbuf       <= ~rbuf;
            end
        end
    end
`else
    assign in_ready   = (state == COLLECT);
    assign switch_buf = 1'b0;
    assign src_buf    = 1'b0;
    assign wbuf       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (accept) begin
            if (blk_cnt < 3'd4)
                y_mem[wbuf][blk_cnt[1:0]] <= in_block;
            else if (blk_cnt == 3'd4)
                cb_mem[wbuf] <= in_block;
            else
                cr_mem[wbuf] <= in_block;
        end
    end

    assign chroma_src = (sub == 2'd1) ? cb_mem[src_buf] : cr_mem[src_buf];

    chroma_quad_sel #(
        .DW (DW)
    ) u_quad_sel (
        .blk  (chroma_src),
        .q    (q),
        .quad (chroma_quad)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            COLLECT: begin
`ifdef CHROMA_SCHED_PINGPONG_EN
                if (full[rbuf] || (fill_done && (wbuf == rbuf)))
                    state_nxt = EMIT;
`else
                if (fill_done)
                    state_nxt = EMIT;
`endif
            end
            EMIT: begin
                if (last_take) begin
                    finish = 1'b1;
                    if (switch_buf)
                        load = 1'b1;
                    else
                        state_nxt = COLLECT;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= COLLECT;
            blk_cnt       <= 3'd0;
            q             <= 2'd0;
            sub           <= 2'd0;
            seq_err       <= 1'b0;
            mcu_done      <= 1'b0;
            out_valid     <= 1'b0;
            out_ch        <= '0;
            out_quad      <= 2'd0;
            out_y_block   <= '0;
            out_sub_block <= '0;
        end else begin
            state    <= state_nxt;
            mcu_done <= finish;
            if (accept) begin
                if (in_ch != CHW'(expected_ch(blk_cnt)))
                    seq_err <= 1'b1;
                blk_cnt <= fill_done ? 3'd0 : blk_cnt + 3'd1;
            end
            // The beat pointer wraps to q=0/sub=0 after the last beat is loaded
            if (load) begin
                out_valid     <= 1'b1;
                out_ch        <= CHW'(sub);
                out_quad      <= q;
                out_y_block   <= (sub == 2'd0) ? y_mem[src_buf][q] : '0;
                out_sub_block <= (sub != 2'd0) ? chroma_quad : '0;
                if (sub == 2'(SUBS - 1)) begin
                    sub <= 2'd0;
                    q   <= q + 2'd1;
                end else begin
                    sub <= sub + 2'd1;
                end
            end else if (finish) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/chroma_mcu_sched.md
Name: chroma_mcu_sched

Overview:
- Sequencer for one 4:2:0 MCU (4 Y blocks, 1 Cb block, 1 Cr block) between the IDCT/level-shift output and the chroma 4x4->8x8 supersampler.
- Collects the six 8x8 blocks in JPEG scan order: Y0, Y1, Y2, Y3, Cb, Cr.
- Re-issues them per luma block: Y_q, then Cb quadrant q (4x4), then Cr quadrant q (4x4).
- Downstream color conversion therefore receives aligned Y/Cb/Cr triplets, with chroma routed through the supersampler.

Parameters:
- DW, 9, sample width (signed), matching the supersampler datapath.
- NCH, `CH, channel count; channel-id width is $clog2(NCH+1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input block valid
- in_ch  in  $clog2(NCH+1)  channel of input block: 0=Y, 1=Cb, 2=Cr
- in_block  in  DW x [7:0][7:0] signed  input 8x8 block
- in_ready  out  1  scheduler accepts block this cycle
- out_valid  out  1  output beat valid
- out_ch  out  $clog2(NCH+1)  channel of output beat; also drives supersampler ch
- out_quad  out  2  MCU quadrant index q of output beat
- out_y_block  out  DW x [7:0][7:0] signed  Y block; meaningful only when out_ch=0, else 0
- out_sub_block  out  DW x [3:0][3:0] signed  chroma quadrant to supersampler; meaningful only when out_ch!=0, else 0
- out_ready  in  1  downstream accepts beat
- mcu_done  out  1  one-cycle pulse on acceptance of the final beat of an MCU
- seq_err  out  1  sticky: in_ch mismatched the expected scan order

Behaviour:
- Reset:
  - state=COLLECT; blk_cnt=0, q=0, sub=0.
  - in_ready=1; out_valid=0, out_ch=0, out_quad=0, mcu_done=0, seq_err=0.
  - Output blocks are 0.
- COLLECT:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_block to buffer slot blk_cnt (0-3 Y, 4 Cb, 5 Cr), then blk_cnt++.
  - Expected in_ch: 0 for blk_cnt 0-3, 1 for 4, 2 for 5.
  - On mismatch: seq_err<=1 (sticky until reset); the block is still stored in slot blk_cnt.
  - On accepting blk_cnt==5: go to EMIT with q=0, sub=0, and blk_cnt<=0.
- EMIT:
  - in_ready=0.
  - Beat order: sub=0 (Y_q, ch 0), sub=1 (Cb quadrant q, ch 1), sub=2 (Cr quadrant q, ch 2).
  - Then q++, up to 12 beats total.
  - Quadrant mapping: q0 = rows0-3/cols0-3; q1 = rows0-3/cols4-7; q2 = rows4-7/cols0-3; q3 = rows4-7/cols4-7.
  - out_sub_block[r][c] = chroma[4*q[1]+r][4*q[0]+c].
- Output registers:
  - out_valid asserts the cycle after entering EMIT; outputs are registered.
  - Outputs hold stable while out_valid&&!out_ready.
  - Advance only on out_valid&&out_ready, giving a throughput of 1 beat/cycle with out_ready tied high.
- End of MCU:
  - Acceptance of the beat with q=3, sub=2 pulses mcu_done for 1 cycle.
  - Same edge: out_valid<=0 and state returns to COLLECT.
  - Minimum MCU period without the optional feature: 6 + 1 + 12 = 19 cycles.
- Asynchronous reset mid-MCU discards partial buffers and returns to the reset state immediately. No partial-MCU flush.
- in_valid while in_ready=0 is ignored; the source must hold the block.

Optional Feature:
- Macro: CHROMA_SCHED_PINGPONG_EN.
- With the macro defined:
  - Two MCU buffers. COLLECT into buffer w runs concurrently with EMIT from buffer r.
  - in_ready=0 only when both buffers are full.
  - The emitter switches to the other buffer on mcu_done if that buffer is full; otherwise out_valid drops.
  - Steady-state period: 12 cycles per MCU.
- Without the macro: single buffer; behaviour exactly as above.

Decomposition:
- Shared package (sched_pkg):
  - ch_t enum: CH_Y=0, CH_CB=1, CH_CR=2.
  - sched_state_t: COLLECT, EMIT.
  - Constants: MCU_BLKS=6, QUADS=4, SUBS=3.
  - blk8_t and blk4_t typedefs at DW.
- One natural sub-module: chroma_quad_sel, a combinational 8x8 + q -> 4x4 extractor shared by Cb and Cr paths.

Test Plan:
- Basic MCU: Y0..Y3 filled with constants 10, 20, 30, 40; Cb[r][c]=r*8+c; Cr=-(r*8+c); out_ready=1.
  - 12 beats in order: ch 0,1,2 per q.
  - Beat q=1, ch=1: out_sub_block[0][0]=4, [3][3]=31.
  - mcu_done on beat 12.
- Backpressure: out_ready toggling 1,0,0,1 during EMIT.
  - Outputs stable across stalls; no beat lost or duplicated.
  - Still exactly 12 beats.
- Order error: second block sent with in_ch=1.
  - seq_err=1 after that accept and stays 1.
  - Scheduler still emits 12 beats after 6 accepts.
- Reset mid-EMIT (after beat 5): all outputs 0 the same cycle.
  - The next full MCU emits correctly from q=0.
- Back-to-back MCUs with in_valid held high:
  - No macro: in_ready low for 13 cycles between MCUs.
  - With CHROMA_SCHED_PINGPONG_EN: second MCU fully accepted during first MCU's EMIT; 24 beats contiguous.
